// File: rtl/invader_march_ctrl.sv
// rtl/invader_march_ctrl.sv - alien fleet march sequencer (frame counting, stepping, edge drop, landing)
//
// Purpose:
//   Counts frame ticks and, every PERIOD counted ticks, steps the fleet horizontally by
//   STEP_X. A step that would leave 0..XMAX turns into a descent of DROP_Y with a direction
//   flip. Once fleet_y reaches Y_LAND the controller locks in LANDED until clr.
//
// Ports:
//   dclk        in   1   pixel clock
//   clr         in   1   synchronous reset, active-high
//   frame_tick  in   1   one-cycle pulse per frame
//   enable      in   1   game running; 0 freezes the frame counter
//   alive_cnt   in   6   invaders alive (0 stops the march)
//   fleet_x     out  10  fleet left edge, px
//   fleet_y     out  10  fleet top edge, px
//   dir         out  1   0 = moving right, 1 = moving left
//   step_pulse  out  1   one-cycle pulse per executed move or drop
//   landed      out  1   sticky landing flag
//
// Configuration macro:
//   MARCH_SPEEDUP_EN  when defined, PERIOD shrinks to alive_cnt once fewer than
//                     FRAMES_PER_STEP invaders remain; otherwise PERIOD = FRAMES_PER_STEP.

module invader_march_ctrl #(
  parameter int SCREEN_W        = 640,
  parameter int FLEET_W         = 256,
  parameter int X_INIT          = 192,
  parameter int Y_INIT          = 64,
  parameter int STEP_X          = 4,
  parameter int DROP_Y          = 16,
  parameter int Y_LAND          = 400,
  parameter int FRAMES_PER_STEP = 30
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [5:0] alive_cnt,
  output logic [9:0] fleet_x,
  output logic [9:0] fleet_y,
  output logic       dir,
  output logic       step_pulse,
  output logic       landed
);

  localparam int          XMAX    = SCREEN_W - FLEET_W;
  localparam int          CW      = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [10:0] XMAX11  = 11'(XMAX);
  localparam logic [10:0] STEP11  = 11'(STEP_X);
  localparam logic [9:0]  STEP10  = 10'(STEP_X);
  localparam logic [10:0] DROP11  = 11'(DROP_Y);
  localparam logic [10:0] YLAND11 = 11'(Y_LAND);
  localparam logic [9:0]  XINIT10 = 10'(X_INIT);
  localparam logic [9:0]  YINIT10 = 10'(Y_INIT);
  localparam logic [6:0]  FPS7    = 7'(FRAMES_PER_STEP);

  typedef enum logic [1:0] {S_WAIT, S_MOVE, S_DROP, S_LANDED} state_t;

  state_t          state;
  logic [CW-1:0]   frame_cnt;
  logic [6:0]      period;
  logic            terminal;
  logic [10:0]     x_plus;
  logic            x_low;
  logic [10:0]     y_next;

  always_comb begin
    period = FPS7;
`ifdef MARCH_SPEEDUP_EN
    if (7'(alive_cnt) < FPS7) begin
      period = 7'(alive_cnt);
    end
`endif
  end

  // frame_cnt >= PERIOD-1 also covers a PERIOD that shrank below the running count.
  // PERIOD is never 0 here because ticks are only counted with alive_cnt != 0.
  assign terminal = (7'(frame_cnt) + 7'd1) >= period;

  // Edge tests are done one bit wider so the right-edge sum cannot wrap.
  assign x_plus = {1'b0, fleet_x} + STEP11;
  assign x_low  = {1'b0, fleet_x} < STEP11;
  assign y_next = {1'b0, fleet_y} + DROP11;

  always_ff @(posedge dclk) begin
    if (clr) begin
      state      <= S_WAIT;
      frame_cnt  <= '0;
      fleet_x    <= XINIT10;
      fleet_y    <= YINIT10;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      landed     <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          step_pulse <= 1'b0;
          if (alive_cnt == 6'd0) begin
            frame_cnt <= '0;
          end else if (frame_tick && enable) begin
            if (terminal) begin
              frame_cnt <= '0;
              state     <= S_MOVE;
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
        end
        S_MOVE: begin
          if ((!dir && (x_plus > XMAX11)) || (dir && x_low)) begin
            step_pulse <= 1'b0;
            state      <= S_DROP;
          end else begin
            fleet_x    <= dir ? (fleet_x - STEP10) : x_plus[9:0];
            step_pulse <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_DROP: begin
          fleet_y    <= y_next[9:0];
          dir        <= ~dir;
          step_pulse <= 1'b1;
          state      <= (y_next >= YLAND11) ? S_LANDED : S_WAIT;
        end
        S_LANDED: begin
          landed     <= 1'b1;
          step_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_invader_march_ctrl.sv
// tb/tb_invader_march_ctrl.sv - self-checking bench for invader_march_ctrl

module tb_invader_march_ctrl;

  logic       dclk = 1'b0;
  logic       clr;
  logic       frame_tick;
  logic       enable;
  logic [5:0] alive_cnt;

  logic [9:0] ox [3];
  logic [9:0] oy [3];
  logic       od [3];
  logic       op [3];
  logic       ol [3];

  always #5 dclk = ~dclk;

  invader_march_ctrl u_dut0 (
    .dclk(dclk), .clr(clr), .frame_tick(frame_tick), .enable(enable), .alive_cnt(alive_cnt),
    .fleet_x(ox[0]), .fleet_y(oy[0]), .dir(od[0]), .step_pulse(op[0]), .landed(ol[0])
  );

  invader_march_ctrl #(.X_INIT(380)) u_dut1 (
    .dclk(dclk), .clr(clr), .frame_tick(frame_tick), .enable(enable), .alive_cnt(alive_cnt),
    .fleet_x(ox[1]), .fleet_y(oy[1]), .dir(od[1]), .step_pulse(op[1]), .landed(ol[1])
  );

  invader_march_ctrl #(.X_INIT(384), .Y_INIT(384)) u_dut2 (
    .dclk(dclk), .clr(clr), .frame_tick(frame_tick), .enable(enable), .alive_cnt(alive_cnt),
    .fleet_x(ox[2]), .fleet_y(oy[2]), .dir(od[2]), .step_pulse(op[2]), .landed(ol[2])
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pcnt [3];

  // Reference model: a step is resolved completely when its tick is counted; the visible
  // results are then scheduled for the edge where they must appear, and ticks are ignored
  // until the step has finished.
  int x_init [3] = '{192, 380, 384};
  int y_init [3] = '{64, 64, 384};
  int lx [3], ly [3], ldir [3], cnt [3], busy [3], upd_at [3], land_at [3], locked [3];
  int vx [3], vy [3], vdir [3], vland [3], vpulse [3];

  task automatic model_edge();
    int per;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        lx[i] = x_init[i]; ly[i] = y_init[i]; ldir[i] = 0;
        vx[i] = x_init[i]; vy[i] = y_init[i]; vdir[i] = 0; vland[i] = 0; vpulse[i] = 0;
        cnt[i] = 0; busy[i] = -1; upd_at[i] = -1; land_at[i] = -1; locked[i] = 0;
      end else begin
        vpulse[i] = 0;
        if (upd_at[i] == cyc) begin
          vx[i] = lx[i]; vy[i] = ly[i]; vdir[i] = ldir[i]; vpulse[i] = 1; upd_at[i] = -1;
        end
        if (land_at[i] == cyc) vland[i] = 1;
        if (!locked[i] && cyc > busy[i]) begin
          if (alive_cnt == 0) begin
            cnt[i] = 0;
          end else if (frame_tick && enable) begin
`ifdef MARCH_SPEEDUP_EN
            per = (int'(alive_cnt) >= 30) ? 30 : int'(alive_cnt);
`else
            per = 30;
`endif
            if (cnt[i] >= per - 1) begin
              cnt[i] = 0;
              if ((ldir[i] == 0 && lx[i] + 4 <= 384) || (ldir[i] == 1 && lx[i] >= 4)) begin
                lx[i] = (ldir[i] == 0) ? lx[i] + 4 : lx[i] - 4;
                upd_at[i] = cyc + 1;
                busy[i] = cyc + 1;
              end else begin
                ly[i] = ly[i] + 16;
                ldir[i] = 1 - ldir[i];
                upd_at[i] = cyc + 2;
                busy[i] = cyc + 2;
                if (ly[i] >= 400) begin
                  locked[i] = 1;
                  land_at[i] = cyc + 3;
                end
              end
            end else begin
              cnt[i] = cnt[i] + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ox[i] !== 10'(vx[i]) || oy[i] !== 10'(vy[i]) || od[i] !== 1'(vdir[i]) ||
          op[i] !== 1'(vpulse[i]) || ol[i] !== 1'(vland[i])) begin
        n_err++;
        $display("FAIL model_inst%0d cyc=%0d got x=%0d y=%0d dir=%0d pulse=%0d landed=%0d required x=%0d y=%0d dir=%0d pulse=%0d landed=%0d",
                 i, cyc, ox[i], oy[i], od[i], op[i], ol[i], vx[i], vy[i], vdir[i], vpulse[i], vland[i]);
      end
    end
  endtask

  task automatic chk(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge dclk);
    cyc++;
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) pcnt[i] += int'(op[i]);
    check_model();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic send_ticks(int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle(); cycle(); cycle();
    end
  endtask

  typedef struct {
    int nt; bit en; int alive;
    int ex0; int ex1; int ey1; int ed1; int ey2; int el2; int np;
  } vec_t;

  vec_t vecs [8];

  initial begin
    clr = 1'b1; frame_tick = 1'b0; enable = 1'b1; alive_cnt = 6'd55;

    vecs[0] = '{30, 1'b1, 55, 196, 384, 64, 0, 400, 1, 1};
    vecs[1] = '{30, 1'b1, 55, 200, 384, 80, 1, 400, 1, 1};
    vecs[2] = '{30, 1'b1, 55, 204, 380, 80, 1, 400, 1, 1};
    vecs[3] = '{50, 1'b0, 55, 204, 380, 80, 1, 400, 1, 0};
    vecs[4] = '{29, 1'b1, 55, 204, 380, 80, 1, 400, 1, 0};
    vecs[5] = '{ 1, 1'b1, 55, 208, 376, 80, 1, 400, 1, 1};
    vecs[6] = '{40, 1'b1,  0, 208, 376, 80, 1, 400, 1, 0};
    vecs[7] = '{30, 1'b1, 55, 212, 372, 80, 1, 400, 1, 1};

    // reset state
    cycle();
    clr = 1'b0;
    chk("reset_x", int'(ox[0]), 192);
    chk("reset_y", int'(oy[0]), 64);
    chk("reset_dir", int'(od[0]), 0);
    chk("reset_pulse", int'(op[0]), 0);
    chk("reset_landed", int'(ol[0]), 0);

    // table-driven march
    for (int v = 0; v < 8; v++) begin
      enable = vecs[v].en;
      alive_cnt = 6'(vecs[v].alive);
      pcnt = '{0, 0, 0};
      send_ticks(vecs[v].nt);
      chk($sformatf("vec%0d_x0", v), int'(ox[0]), vecs[v].ex0);
      chk($sformatf("vec%0d_y0", v), int'(oy[0]), 64);
      chk($sformatf("vec%0d_x1", v), int'(ox[1]), vecs[v].ex1);
      chk($sformatf("vec%0d_y1", v), int'(oy[1]), vecs[v].ey1);
      chk($sformatf("vec%0d_dir1", v), int'(od[1]), vecs[v].ed1);
      chk($sformatf("vec%0d_x2", v), int'(ox[2]), 384);
      chk($sformatf("vec%0d_y2", v), int'(oy[2]), vecs[v].ey2);
      chk($sformatf("vec%0d_landed2", v), int'(ol[2]), vecs[v].el2);
      chk($sformatf("vec%0d_pulses0", v), pcnt[0], vecs[v].np);
      chk($sformatf("vec%0d_pulses1", v), pcnt[1], vecs[v].np);
    end

    // step latency: plain step at N+1, drop at N+2, landed flag after
    enable = 1'b1; alive_cnt = 6'd55;
    do_clr();
    send_ticks(29);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    chk("lat_n_x0", int'(ox[0]), 192);
    chk("lat_n_pulse0", int'(op[0]), 0);
    cycle();
    chk("lat_n1_x0", int'(ox[0]), 196);
    chk("lat_n1_pulse0", int'(op[0]), 1);
    chk("lat_n1_y2", int'(oy[2]), 384);
    chk("lat_n1_pulse2", int'(op[2]), 0);
    cycle();
    chk("lat_n2_pulse0", int'(op[0]), 0);
    chk("lat_n2_y2", int'(oy[2]), 400);
    chk("lat_n2_dir2", int'(od[2]), 1);
    chk("lat_n2_pulse2", int'(op[2]), 1);
    chk("lat_n2_landed2", int'(ol[2]), 0);
    cycle();
    chk("lat_n3_landed2", int'(ol[2]), 1);
    chk("lat_n3_pulse2", int'(op[2]), 0);

    // clr the cycle after MOVE entry
    do_clr();
    send_ticks(29);
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    pcnt = '{0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      chk("clrmove_x0", int'(ox[0]), 192);
      chk("clrmove_y2", int'(oy[2]), 384);
      chk("clrmove_dir2", int'(od[2]), 0);
      cycle();
    end
    chk("clrmove_pulses0", pcnt[0], 0);
    chk("clrmove_pulses2", pcnt[2], 0);

    // few survivors
    do_clr();
    alive_cnt = 6'd5;
    send_ticks(5);
`ifdef MARCH_SPEEDUP_EN
    chk("speed5_x0", int'(ox[0]), 196);
    send_ticks(5);
    chk("speed10_x0", int'(ox[0]), 200);
`else
    chk("speed5_x0", int'(ox[0]), 192);
    send_ticks(25);
    chk("speed30_x0", int'(ox[0]), 196);
`endif

    // randomized run against the model
    do_clr();
    for (int k = 0; k < 5000; k++) begin
      clr = ($urandom_range(0, 249) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 3))
          0: alive_cnt = 6'd0;
          1: alive_cnt = 6'($urandom_range(1, 6));
          2: alive_cnt = 6'd55;
          default: alive_cnt = 6'($urandom_range(0, 55));
        endcase
      end
      cycle();
    end
    clr = 1'b0; frame_tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
